// File: rtl/lupa_pkg.sv
// lupa_pkg: shared state encoding, default timing constants and helpers for the LUPA300 exposure sequencer
// Contents: state_t (PWRUP..FOT), DEF_RST_WAIT, DEF_RSTN_HOLD, DEF_FOT_CYCLES, LINE_W, max2()
package lupa_pkg;

    typedef enum logic [2:0] {
        PWRUP    = 3'd0,
        RELEASE  = 3'd1,
        CFG_REQ  = 3'd2,
        CFG_WAIT = 3'd3,
        ARM      = 3'd4,
        INTEG    = 3'd5,
        FOT      = 3'd6
    } state_t;

    localparam int DEF_RST_WAIT   = 20000;
    localparam int DEF_RSTN_HOLD  = 60;
    localparam int DEF_FOT_CYCLES = 624;
    localparam int LINE_W         = 9;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/lupa_edge_sync.sv
// lupa_edge_sync: optional 2-flop synchronizer plus rise/fall pulse generator for one sensor strobe
// Ports: i_clk, i_rst_n (async active-low), i_d (raw strobe),
//        o_lvl (strobe as seen by the core), o_rise / o_fall (single-cycle edge pulses)
// Build option: LUPA_EXPSCHED_INPUT_SYNC_EN inserts the 2-flop synchronizer (+2 cycles latency)
module lupa_edge_sync
    import lupa_pkg::*;
(
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_lvl,
    output logic o_rise,
    output logic o_fall
);

    logic r_q;
    logic w_d;

`ifdef LUPA_EXPSCHED_INPUT_SYNC_EN
    logic [1:0] r_sync;

    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n) r_sync <= '0;
        else          r_sync <= {r_sync[0], i_d};

    assign w_d = r_sync[1];
`else
    // Strobe is already synchronous to the sensor clock; only one history flop is kept.
    assign w_d = i_d;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n) r_q <= 1'b0;
        else          r_q <= w_d;

    assign o_lvl  = w_d;
    assign o_rise = w_d & ~r_q;
    assign o_fall = ~w_d & r_q;

endmodule

// File: rtl/lupa_exposure_sched.sv
// lupa_exposure_sched: LUPA300 power-up, SPI-config handshake, exposure pulse and frame-store selection sequencer
// Ports: iCLOCK_80 (clock), iRST_N (async active-low reset), iEXP_CYCLES (exposure length),
//        iFRAME_DIV (keep 1 of every N+1 frames), iRECFG (reconfig request pulse), iCFG_DONE (uploader done level),
//        Frame_Valid / Line_Valid (sensor strobes), oSENSOR_RST_N, oCFG_START (upload start pulse),
//        oINT_TIME (integration), oWRT_FLAG (frame-store write enable), oLINE_CNT (completed lines), oSTATE (debug)
// Build option: LUPA_EXPSCHED_INPUT_SYNC_EN synchronizes Frame_Valid / Line_Valid (see lupa_edge_sync)
module lupa_exposure_sched
    import lupa_pkg::*;
#(
    parameter int RST_WAIT   = DEF_RST_WAIT,
    parameter int RSTN_HOLD  = DEF_RSTN_HOLD,
    parameter int FOT_CYCLES = DEF_FOT_CYCLES,
    parameter int EXP_W      = 21
) (
    input  logic              iCLOCK_80,
    input  logic              iRST_N,
    input  logic [EXP_W-1:0]  iEXP_CYCLES,
    input  logic [4:0]        iFRAME_DIV,
    input  logic              iRECFG,
    input  logic              iCFG_DONE,
    input  logic              Frame_Valid,
    input  logic              Line_Valid,
    output logic              oSENSOR_RST_N,
    output logic              oCFG_START,
    output logic              oINT_TIME,
    output logic              oWRT_FLAG,
    output logic [LINE_W-1:0] oLINE_CNT,
    output logic [2:0]        oSTATE
);

    localparam int CNT_W = max2(EXP_W, max2($clog2(RST_WAIT), max2($clog2(RSTN_HOLD), $clog2(FOT_CYCLES))));

    state_t            r_state;
    state_t            w_next;
    logic [CNT_W-1:0]  r_cnt;
    logic [EXP_W-1:0]  r_exp_m1;
    logic [4:0]        r_fcnt;
    logic [LINE_W-1:0] r_line;
    logic              r_cfg_start;
    logic              r_pend;
    logic              r_srst;
    logic              r_int;
    logic              r_wrt;
    logic              r_sel;
    logic              w_fv;
    logic              w_fv_rise;
    logic              w_fv_fall;
    logic              w_lv_lvl;
    logic              w_lv_rise;
    logic              w_lv_fall;
    logic              w_start;
    logic              w_unused;

    lupa_edge_sync u_fv (
        .i_clk   (iCLOCK_80),
        .i_rst_n (iRST_N),
        .i_d     (Frame_Valid),
        .o_lvl   (w_fv),
        .o_rise  (w_fv_rise),
        .o_fall  (w_fv_fall)
    );

    lupa_edge_sync u_lv (
        .i_clk   (iCLOCK_80),
        .i_rst_n (iRST_N),
        .i_d     (Line_Valid),
        .o_lvl   (w_lv_lvl),
        .o_rise  (w_lv_rise),
        .o_fall  (w_lv_fall)
    );

    // Only the falling edge of Line_Valid matters for line counting.
    assign w_unused = w_lv_rise ^ w_lv_lvl;

    always_comb begin
        w_next = r_state;
        case (r_state)
            PWRUP:    w_next = (r_cnt == CNT_W'(RST_WAIT - 1))   ? RELEASE  : PWRUP;
            RELEASE:  w_next = (r_cnt == CNT_W'(RSTN_HOLD - 1))  ? CFG_REQ  : RELEASE;
            CFG_REQ:  w_next = r_cfg_start                       ? CFG_WAIT : CFG_REQ;
            CFG_WAIT: w_next = iCFG_DONE                         ? ARM      : CFG_WAIT;
            ARM:      w_next = w_fv_fall ? (r_pend ? CFG_REQ : INTEG) : ARM;
            INTEG:    w_next = (r_cnt == CNT_W'(r_exp_m1))       ? FOT      : INTEG;
            FOT:      w_next = (r_cnt == CNT_W'(FOT_CYCLES - 1)) ? ARM      : FOT;
            default:  w_next = PWRUP;
        endcase
    end

    // The start pulse is issued on the same edge that enters CFG_REQ when Frame_Valid is already low,
    // so CFG_REQ lasts exactly one cycle in that case; otherwise it waits for Frame_Valid to drop.
    assign w_start = (w_next == CFG_REQ) && !w_fv && !r_cfg_start;

    always_ff @(posedge iCLOCK_80 or negedge iRST_N)
        if (!iRST_N) r_state <= PWRUP;
        else         r_state <= w_next;

    always_ff @(posedge iCLOCK_80 or negedge iRST_N) begin
        if (!iRST_N) begin
            r_cnt       <= '0;
            r_exp_m1    <= '0;
            r_fcnt      <= '0;
            r_line      <= '0;
            r_cfg_start <= 1'b0;
            r_pend      <= 1'b0;
            r_srst      <= 1'b0;
            r_int       <= 1'b0;
            r_wrt       <= 1'b0;
            r_sel       <= 1'b0;
        end else begin
            // One counter serves every timed state; it restarts on each state change.
            r_cnt       <= (w_next != r_state) ? '0 : r_cnt + CNT_W'(1);
            if (r_state != INTEG && w_next == INTEG)
                r_exp_m1 <= (iEXP_CYCLES == '0) ? '0 : iEXP_CYCLES - EXP_W'(1);
            r_cfg_start <= w_start;
            r_pend      <= w_start ? 1'b0 : (r_pend | (iRECFG && (r_state inside {CFG_WAIT, ARM, INTEG, FOT})));
            r_srst      <= (w_next != PWRUP);
            r_int       <= (w_next == INTEG);
            // Selection is decided from the counter value at frame start and held for the whole frame.
            if (w_fv_rise) begin
                r_fcnt <= (r_fcnt >= iFRAME_DIV) ? '0 : r_fcnt + 5'd1;
                r_sel  <= (r_fcnt == '0);
            end
            r_wrt       <= w_fv && (w_fv_rise ? (r_fcnt == '0) : r_sel);
            r_line      <= w_fv_rise ? '0 : (w_lv_fall && r_line != '1) ? r_line + LINE_W'(1) : r_line;
        end
    end

    assign oSENSOR_RST_N = r_srst;
    assign oCFG_START    = r_cfg_start;
    assign oINT_TIME     = r_int;
    assign oWRT_FLAG     = r_wrt;
    assign oLINE_CNT     = r_line;
    assign oSTATE        = r_state;

endmodule

// File: tb/tb_lupa_exposure_sched.sv
// tb_lupa_exposure_sched: randomized self-checking bench for lupa_exposure_sched against a behavioural timing model
module tb_lupa_exposure_sched;

    localparam int RST_WAIT  = 100;
    localparam int RSTN_HOLD = 10;
    localparam int FOT       = 624;
    localparam int EXP_W     = 21;
`ifdef LUPA_EXPSCHED_INPUT_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [EXP_W-1:0] exp_cyc = '0;
    logic [4:0]       frame_div = '0;
    logic             recfg = 1'b0;
    logic             cfg_done = 1'b0;
    logic             fv = 1'b0;
    logic             lv = 1'b0;
    logic             srst_n;
    logic             cfg_start;
    logic             int_time;
    logic             wrt;
    logic [8:0]       line_cnt;
    logic [2:0]       state;
    int               n_tests = 0;
    int               n_fail = 0;

    always #6 clk = ~clk;

    lupa_exposure_sched #(
        .RST_WAIT   (RST_WAIT),
        .RSTN_HOLD  (RSTN_HOLD),
        .FOT_CYCLES (FOT),
        .EXP_W      (EXP_W)
    ) dut (
        .iCLOCK_80     (clk),
        .iRST_N        (rst_n),
        .iEXP_CYCLES   (exp_cyc),
        .iFRAME_DIV    (frame_div),
        .iRECFG        (recfg),
        .iCFG_DONE     (cfg_done),
        .Frame_Valid   (fv),
        .Line_Valid    (lv),
        .oSENSOR_RST_N (srst_n),
        .oCFG_START    (cfg_start),
        .oINT_TIME     (int_time),
        .oWRT_FLAG     (wrt),
        .oLINE_CNT     (line_cnt),
        .oSTATE        (state)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic reset_and_bringup();
        int rise_at = -1;
        int start_at = -1;
        int starts = 0;
        rst_n = 1'b0; fv = 1'b0; lv = 1'b0; recfg = 1'b0; cfg_done = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_state", int'(state), 0);
        check("rst_outs", int'({srst_n, cfg_start, int_time, wrt}), 0);
        check("rst_lines", int'(line_cnt), 0);
        rst_n = 1'b1;
        for (int k = 1; k <= RST_WAIT + RSTN_HOLD + 20; k++) begin
            @(negedge clk);
            if (srst_n && rise_at < 0) rise_at = k;
            if (cfg_start) begin
                starts++;
                if (start_at < 0) start_at = k;
            end
        end
        check("srst_rise_cycle", rise_at, RST_WAIT);
        check("cfg_start_cycle", start_at, RST_WAIT + RSTN_HOLD);
        check("cfg_start_count", starts, 1);
        check("state_cfg_wait", int'(state), 3);
    endtask

    // Drives one frame of nlines lines (2 cycles high, 1 low each); leaves Frame_Valid just dropped.
    task automatic frame(input int nlines, output int wrt_seen, output int lines_seen);
        fv = 1'b1;
        @(negedge clk);
        for (int i = 0; i < nlines; i++) begin
            lv = 1'b1;
            repeat (2) @(negedge clk);
            lv = 1'b0;
            @(negedge clk);
        end
        repeat (3) @(negedge clk);
        wrt_seen = int'(wrt);
        lines_seen = int'(line_cnt);
        fv = 1'b0;
    endtask

    // Measures the exposure that follows a Frame_Valid fall just driven by frame().
    task automatic expose(input int exp_req, input bit disturb, input bit do_recfg);
        int lat = 0;
        int hi = 0;
        int lo = 0;
        int starts = 0;
        int want;
        want = (exp_req == 0) ? 1 : exp_req;
        while (!int_time && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        check("int_latency", lat, LAT);
        while (int_time && hi < want + 50) begin
            hi++;
            if (disturb && hi == 2) begin
                exp_cyc = EXP_W'($urandom_range(1, 5000));
                cfg_done = 1'b0;
                fv = 1'b1;
            end
            if (disturb && hi == 4) fv = 1'b0;
            if (do_recfg && hi == 3) begin
                recfg = 1'b1;
                cfg_done = 1'b0;
            end
            if (do_recfg && hi == 4) recfg = 1'b0;
            @(negedge clk);
            starts += int'(cfg_start);
        end
        check("int_width", hi, want);
        while (!int_time && state != 3'd4 && lo < FOT + 50) begin
            lo++;
            @(negedge clk);
            starts += int'(cfg_start);
        end
        check("fot_gap", lo, FOT);
        check("arm_after_fot", int'(state), 4);
        check("no_cfg_start", starts, 0);
    endtask

    initial begin
        int w, l, e, nl, div, starts, seen_int;
        reset_and_bringup();

        frame_div = 5'd3;
        for (int f = 0; f < 8; f++) begin
            frame(2, w, l);
            check("wrt_div3", w, int'(f % 4 == 0));
            check("lines_div3", l, 2);
            repeat (4) @(negedge clk);
            check("wrt_idle", int'(wrt), 0);
        end

        div = int'($urandom_range(0, 7));
        frame_div = 5'(div);
        reset_and_bringup();
        for (int f = 0; f < 2 * (div + 1) + 2; f++) begin
            nl = int'($urandom_range(0, 40));
            frame(nl, w, l);
            check("wrt_rand", w, int'(f % (div + 1) == 0));
            check("lines_rand", l, nl);
            repeat (3) @(negedge clk);
        end

        frame(480, w, l);
        check("lines_480", l, 480);
        repeat (5) @(negedge clk);
        check("lines_hold", int'(line_cnt), 480);
        frame(600, w, l);
        check("lines_sat", l, 511);
        repeat (3) @(negedge clk);

        cfg_done = 1'b1;
        @(negedge clk);
        check("arm_after_cfg", int'(state), 4);
        for (int i = 0; i < 8; i++) begin
            e = (i == 0) ? 50 : (i == 1) ? 0 : (i == 2) ? 1 : int'($urandom_range(0, 400));
            exp_cyc = EXP_W'(e);
            nl = int'($urandom_range(1, 20));
            frame(nl, w, l);
            check("lines_exp", l, nl);
            expose(e, 1'b0, 1'b0);
        end

        exp_cyc = EXP_W'(100);
        frame(3, w, l);
        expose(100, 1'b1, 1'b0);
        repeat (5) @(negedge clk);
        check("fall_dropped_state", int'(state), 4);
        check("fall_dropped_int", int'(int_time), 0);

        exp_cyc = EXP_W'(30);
        frame(3, w, l);
        expose(30, 1'b0, 1'b1);
        repeat (5) @(negedge clk);
        check("recfg_wait_arm", int'(state), 4);
        frame(3, w, l);
        starts = 0;
        seen_int = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            starts += int'(cfg_start);
            seen_int |= int'(int_time);
        end
        check("recfg_pulses", starts, 1);
        check("recfg_state", int'(state), 3);
        check("recfg_no_int", seen_int, 0);
        cfg_done = 1'b1;
        @(negedge clk);
        check("recfg_rearm", int'(state), 4);
        exp_cyc = EXP_W'(20);
        frame(2, w, l);
        expose(20, 1'b0, 1'b0);

        exp_cyc = EXP_W'(200);
        frame(2, w, l);
        for (int k = 0; k < 10 && !int_time; k++) @(negedge clk);
        repeat (5) @(negedge clk);
        check("integ_before_rst", int'(state), 5);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_int", int'(int_time), 0);
        check("rst_mid_srst", int'(srst_n), 0);
        check("rst_mid_state", int'(state), 0);
        reset_and_bringup();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, tests run %0d", n_tests);
        $fatal(1);
    end

endmodule

// File: doc/lupa_exposure_sched.md
# lupa_exposure_sched

Sequencer for the LUPA300 image sensor. It runs the power-up reset of the sensor, requests the SPI register upload and waits for it to finish. It then generates one integration (exposure) pulse per frame with a programmable length, followed by a fixed frame-overhead-time (FOT) guard. It also selects which frames are written to the frame store, and sits between the 80 MHz sensor clock domain logic, the SPI uploader and the FIFO write path.

## Interface
Parameters:
- RST_WAIT, 20000: cycles the sensor reset is held low after iRST_N deasserts (VDDD settle).
- RSTN_HOLD, 60: cycles after sensor reset release before the config request.
- FOT_CYCLES, 624: cycles oINT_TIME is held low after each integration.
- EXP_W, 21: width of the exposure length input.

Ports:
- iCLOCK_80  in  1  sole clock, 80 MHz.
- iRST_N  in  1  asynchronous, active-low reset.
- iEXP_CYCLES  in  EXP_W  integration length in clock cycles; sampled on entry to INTEG.
- iFRAME_DIV  in  5  capture one frame in every iFRAME_DIV+1 frames.
- iRECFG  in  1  single-cycle pulse requesting a new register upload.
- iCFG_DONE  in  1  level from the SPI uploader; high while the configuration is complete.
- Frame_Valid  in  1  sensor frame-valid signal.
- Line_Valid  in  1  sensor line-valid signal.
- oSENSOR_RST_N  out  1  sensor RST_N drive.
- oCFG_START  out  1  one-cycle pulse that starts the SPI upload.
- oINT_TIME  out  1  high during integration.
- oWRT_FLAG  out  1  high while Frame_Valid is high in a selected frame.
- oLINE_CNT  out  9  completed lines in the current frame.
- oSTATE  out  3  current FSM state encoding, for debug.

## Operation
States and encodings: PWRUP=0, RELEASE=1, CFG_REQ=2, CFG_WAIT=3, ARM=4, INTEG=5, FOT=6.
- PWRUP: oSENSOR_RST_N=0 and the counter runs. After RST_WAIT cycles -> RELEASE.
- RELEASE: oSENSOR_RST_N=1. After RSTN_HOLD cycles -> CFG_REQ.
- CFG_REQ: wait for synchronized Frame_Valid low, then pulse oCFG_START for exactly 1 cycle -> CFG_WAIT.
- CFG_WAIT: on iCFG_DONE=1 -> ARM.
- ARM: on a Frame_Valid falling edge, go to CFG_REQ if a reconfiguration is pending, otherwise go to INTEG.
- INTEG: on entry, latch max(iEXP_CYCLES,1). oINT_TIME=1 for exactly that many cycles -> FOT.
- FOT: oINT_TIME=0 for FOT_CYCLES cycles -> ARM.

Pending reconfiguration:
- iRECFG sets a sticky pending flag in any state from CFG_WAIT onward.
- The flag is cleared when oCFG_START is issued.
- It is serviced only from ARM.

Frame selection:
- A 5-bit frame counter increments on each Frame_Valid rising edge and wraps to 0 after reaching iFRAME_DIV.
- oWRT_FLAG = synchronized Frame_Valid AND (counter==0).
- With iFRAME_DIV=0, every frame is selected.

Line count:
- oLINE_CNT clears on a Frame_Valid rising edge and increments on each Line_Valid falling edge.
- It saturates at 511.

Boundary conditions:
- A Frame_Valid edge during INTEG or FOT does not affect exposure timing; a falling edge seen there is dropped and the FSM waits for the next one in ARM.
- iCFG_DONE falling in ARM, INTEG or FOT is ignored.
- iEXP_CYCLES changing mid-INTEG is ignored.
- iRST_N low at any time: immediately returns to PWRUP with all outputs at their reset values.

## Timing
- Reset values: oSENSOR_RST_N=0, oCFG_START=0, oINT_TIME=0, oWRT_FLAG=0, oLINE_CNT=0, oSTATE=0, frame counter=0, pending flag=0.
- All outputs are registered.
- Edge detection latency: 1 cycle from the (synchronized) input to the FSM reacting. A Frame_Valid falling edge raises oINT_TIME 1 cycle later, plus 2 more cycles if the synchronizer is enabled.
- From iRST_N release: oSENSOR_RST_N rises at cycle RST_WAIT and oCFG_START pulses at cycle RST_WAIT+RSTN_HOLD at the earliest.
- oINT_TIME high width equals the latched exposure exactly; the low gap before the next ARM is exactly FOT_CYCLES.

## Configuration
- LUPA_EXPSCHED_INPUT_SYNC_EN defined: Frame_Valid and Line_Valid each pass through a 2-flop synchronizer before edge detection, adding 2 cycles of latency on all derived events and on oWRT_FLAG.
- Not defined: the inputs are registered once, for edge detection only, because they are treated as synchronous to iCLOCK_80.

## Structure
- Shared package lupa_pkg holds:
  - the state enum and its encodings;
  - default constants for RST_WAIT, RSTN_HOLD and FOT_CYCLES;
  - the line-count width of 9.
- One sub-module, lupa_edge_sync: an optional synchronizer plus rise/fall pulse generator, instantiated for Frame_Valid and Line_Valid.
- The FSM, the cycle counter (shared across PWRUP, RELEASE, INTEG and FOT), the frame counter and the line counter live in the top module.

## Test plan
- Reset with RST_WAIT=100 and RSTN_HOLD=10: oSENSOR_RST_N rises at cycle 100, oCFG_START pulses once at cycle 110, and oSTATE=3.
- iCFG_DONE=1, iEXP_CYCLES=50, Frame_Valid falling: oINT_TIME is high for exactly 50 cycles, low for 624 cycles, then oSTATE=4.
- iEXP_CYCLES=0: oINT_TIME is high for 1 cycle.
- iFRAME_DIV=3 over 8 frames: oWRT_FLAG is high in frames 0 and 4 only.
- Frame with 480 Line_Valid pulses: oLINE_CNT=480 at Frame_Valid fall; 600 pulses saturate at 511.
- iRECFG pulsed during INTEG: no oCFG_START until FOT finishes and the next Frame_Valid falls. Then exactly one pulse occurs and oSTATE=3.
- iRST_N dropped mid-INTEG: oINT_TIME=0, oSENSOR_RST_N=0 and oSTATE=0 immediately.
